// File: rtl/bcd_pkg.sv
// Shared BCD constants and the nibble sanitiser used on parallel load.
package bcd_pkg;
  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Non-decimal nibbles (A..F) clamp to 9 so the counter never holds an illegal digit.
  function automatic logic [BCD_W-1:0] bcd_sanitise(input logic [BCD_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit counting 9..0 with wrap to 9; load has priority over decrement.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk_div,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             dec_in,
  output logic [BCD_W-1:0] q,
  output logic             is_zero
);

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      q <= BCD_ZERO;
    end else if (load) begin
      q <= bcd_sanitise(ld_val);
    end else if (dec_in) begin
      q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
    end
  end

  assign is_zero = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded DIGITS-digit BCD down-counter with load, enable, zero flag and borrow-out.
// Define BCD_HOLD_AT_ZERO_EN for one-shot timer mode (holds at 0 instead of wrapping to all 9s).
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk_div,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] din,
  output logic [BCD_W*DIGITS-1:0] dout,
  output logic                    zero,
  output logic                    borrow
);

  logic [DIGITS-1:0] dig_zero;
  logic [DIGITS-1:0] low_zero;
  logic              all_zero;
  logic              count;

  // low_zero[i]: every digit below i reads 0, so digit i takes the borrow.
  always_comb begin
    all_zero = 1'b1;
    low_zero = '0;
    for (int k = 0; k < DIGITS; k++) begin
      low_zero[k] = all_zero;
      all_zero    = all_zero & dig_zero[k];
    end
  end

`ifdef BCD_HOLD_AT_ZERO_EN
  assign count = en & ~load & ~all_zero;
`else
  assign count = en & ~load;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk_div (clk_div),
      .rst_n   (rst_n),
      .load    (load),
      .ld_val  (din[BCD_W*i +: BCD_W]),
      .dec_in  (count & low_zero[i]),
      .q       (dout[BCD_W*i +: BCD_W]),
      .is_zero (dig_zero[i])
    );
  end

  assign zero = all_zero;
  // Qualified by rst_n so a downstream stage sees no borrow while this one is held in reset.
  assign borrow = rst_n & en & ~load & all_zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed plus randomized bench for bcd_down_counter against a decimal-integer reference model.
module tb_bcd_down_counter;
  localparam int D   = 2;
  localparam int W   = 4 * D;
  localparam int MOD = 100;

  logic         clk_div = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         zero;
  logic         borrow;

  int vectors    = 0;
  int miscompares = 0;
  int val        = 0;

  bcd_down_counter #(.DIGITS(D)) dut (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .din     (din),
    .dout    (dout),
    .zero    (zero),
    .borrow  (borrow)
  );

  always #5 clk_div = ~clk_div;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [W-1:0] d);
    int v;
    int scale;
    int n;
    v = 0;
    scale = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(d[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".dout"}, 32'(dout), 32'(to_bcd(val)));
    chk({tag, ".zero"}, 32'(zero), 32'(val == 0));
  endtask

  // Called at a negedge: drive inputs, check borrow, take one edge, check the new state.
  task automatic cycle(input string tag, input logic l, input logic e, input logic [W-1:0] d);
    load = l;
    en   = e;
    din  = d;
    #1;
    chk({tag, ".borrow"}, 32'(borrow), 32'(e && !l && val == 0));
    @(posedge clk_div);
    if (l) begin
      val = load_value(d);
    end else if (e) begin
`ifdef BCD_HOLD_AT_ZERO_EN
      val = (val == 0) ? 0 : val - 1;
`else
      val = (val == 0) ? MOD - 1 : val - 1;
`endif
    end
    #1;
    check_state(tag);
    @(negedge clk_div);
  endtask

  // Asynchronous clear between edges, held across one active edge, released at a negedge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    val = 0;
    #1;
    check_state({tag, ".async"});
    chk({tag, ".rst_borrow"}, 32'(borrow), 32'(0));
    @(posedge clk_div);
    #1;
    check_state({tag, ".held"});
    @(negedge clk_div);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    din   = '0;
    #1;
    check_state("reset");
    chk("reset.borrow", 32'(borrow), 32'(0));
    @(negedge clk_div);
    rst_n = 1'b1;

    // Reset while counting at 37, then wrap from 00 on the first edge.
    cycle("t1.load", 1'b1, 1'b0, 8'h37);
    en = 1'b1;
    async_reset("t1");
    cycle("t1.wrap", 1'b0, 1'b1, 8'h00);

    // Load and count through a decade borrow.
    cycle("t2.load", 1'b1, 1'b0, 8'h25);
    for (int i = 0; i < 6; i++) cycle("t2.count", 1'b0, 1'b1, 8'h00);

    // Full wrap through 00.
    cycle("t3.load", 1'b1, 1'b0, 8'h03);
    for (int i = 0; i < 5; i++) cycle("t3.count", 1'b0, 1'b1, 8'h00);

    // load beats en; A/F digits load as 9; hold with en low.
    cycle("t4.prio", 1'b1, 1'b1, 8'hAF);
    for (int i = 0; i < 10; i++) cycle("t4.hold", 1'b0, 1'b0, 8'h00);

    // Async reset while counting at 50, then load 12.
    cycle("t5.load", 1'b1, 1'b0, 8'h50);
    cycle("t5.count", 1'b0, 1'b1, 8'h00);
    async_reset("t5");
    cycle("t5.reload", 1'b1, 1'b0, 8'h12);

    // Countdown past zero (hold or wrap depending on build), then load from there.
    cycle("t6.load", 1'b1, 1'b0, 8'h02);
    for (int i = 0; i < 5; i++) cycle("t6.count", 1'b0, 1'b1, 8'h00);
    cycle("t6.reload", 1'b1, 1'b0, 8'h40);

    // Randomized mix; small-value loads make zero crossings frequent.
    for (int i = 0; i < 400; i++) begin
      logic         l;
      logic         e;
      logic [W-1:0] d;
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 9) < 8);
      d = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        en = e;
        load = 1'b0;
        async_reset("rnd");
      end else begin
        cycle("rnd", l, e, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
Cascaded multi-digit BCD down-counter. It is the counting-down counterpart of the team's decade up-counter and shares its clock domain (clk_div).
- Each digit counts 9,8,...,0 and wraps to 9, borrowing from the next-higher digit.
- Supports synchronous load, count enable, a borrow-out for chaining further counters, and a zero flag for countdown/timer use (e.g. 7-segment countdown display).

Parameters:
DIGITS, 2, number of BCD digits (1..4); dout width = 4*DIGITS

Ports:
clk_div  input  1  counter clock; all state updates on its rising edge
rst_n  input  1  asynchronous reset, active-low
en  input  1  count enable; decrement by one per clk_div edge when high
load  input  1  synchronous load of din; priority over en
din  input  4*DIGITS  parallel load value, digit i at bits [4i+3:4i]
dout  output  4*DIGITS  current count, packed BCD, digit 0 = least significant
zero  output  1  high when every digit of dout is 0
borrow  output  1  combinational: en & zero & ~load; high in the cycle whose edge wraps 0..0 -> 9..9

Behaviour:
- Reset: rst_n low asynchronously forces dout = 0. zero = 1 and borrow = 0 (en permitted low) for the whole time reset is asserted.
- Per rising clk_div edge, with rst_n high, priority order:
  1. load=1: dout <= din, after per-digit sanitising. Any din digit > 9 (A..F) loads as 9. en is ignored this cycle.
  2. en=1: digit 0 decrements.
     - Digit i decrements only if every lower digit is 0. That digit then wraps 0 -> 9 and the next digit decrements.
     - Example: 2 digits, 10 -> 09; 00 -> 99.
  3. Otherwise hold.
- Latency: dout reflects load/decrement one edge after the controlling input is sampled. zero is combinational from dout (no extra cycle).
- borrow is purely combinational, for a higher-order counter stage. A following stage uses it as its own en, so the chain decrements in the same edge.
- Digit legality: dout digits are always in 0..9. Reachable states never contain A..F.
- Reset mid-count: asynchronous clear wins immediately. The first active edge after rst_n deasserts obeys load/en normally.
- load and en both high: load wins, no decrement, borrow = 0.
- en low: dout holds indefinitely; borrow = 0.

Optional Feature:
BCD_HOLD_AT_ZERO_EN
- Defined (one-shot timer mode): when dout = 0 and en = 1 with load = 0, dout holds at 0 (no wrap). borrow still pulses high each such cycle so a timer-done event is visible. load still works from zero.
- Not defined: wrap to all-9s as described in Behaviour.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - function for sanitising a nibble (>9 -> 9)
- Sub-module bcd_down_digit, one 4-bit digit:
  - Inputs: clk_div, rst_n, load, ld_val, dec_in.
  - Outputs: q, is_zero.
- Top level generates DIGITS instances. dec_in for digit i = en & ~load & all lower digits zero. borrow and zero are formed from the is_zero outputs.

Test Plan:
1. Reset: rst_n=0 while dout=37 and en=1 -> dout=00, zero=1 immediately (before next edge). Release, en=1 -> next edge dout=99, borrow=1 during the 00 cycle.
2. Load/count: load din=0x25 for one edge, then en=1 for 6 edges -> dout sequence 25,24,23,22,21,20,19. Decade borrow from 20->19 is correct; borrow=0 throughout.
3. Full wrap: load 0x03, en=1 for 5 edges -> 03,02,01,00,99,98. borrow=1 only in the 00 cycle; zero=1 only in the 00 cycle.
4. Priority and invalid digits: load=1, en=1, din=0xAF -> dout=99 after one edge with no decrement, borrow=0. en=0 for 10 edges -> dout stays 99.
5. Async reset mid-operation: assert rst_n low asynchronously between edges during counting at 50 -> dout=00 without a clock edge. Deassert; load 0x12 on the next edge -> 12.
6. With BCD_HOLD_AT_ZERO_EN: load 0x02, en=1 for 5 edges -> 01,00,00,00,00, borrow high in each 00 cycle. load 0x40 -> 40. Without the macro, the same stimulus gives 01,00,99,98,97.
